// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if: requester <-> scheduler bundle.
// master = requesters (req/delay_ms/cancel); slave = scheduler (ack/busy/done/tick).
interface timer_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int DW     = 16
);
   logic [NUM_CH-1:0]    req;
   logic [NUM_CH*DW-1:0] delay_ms;
   logic [NUM_CH-1:0]    cancel;
   logic [NUM_CH-1:0]    ack;
   logic [NUM_CH-1:0]    busy;
   logic [NUM_CH-1:0]    done;
   logic                 tick;

   modport master (
      output req, delay_ms, cancel,
      input  ack, busy, done, tick
   );

   modport slave (
      input  req, delay_ms, cancel,
      output ack, busy, done, tick
   );
endinterface

// File: rtl/timer_scheduler.sv
// timer_scheduler: shared ms prescaler + NUM_CH one-shot delay channels, rr arbiter.
// Ports: clk, reset (sync, active-high), bus (slave: req/delay_ms/cancel in; ack/busy/done/tick out).
module timer_scheduler #(
   parameter int NUM_CH     = 4,
   parameter int CLK_PER_MS = 100_000,
   parameter int DW         = 16
) (
   input  logic              clk,
   input  logic              reset,
   timer_scheduler_if.slave  bus
);
   localparam int          CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [31:0] PMAX = 32'(CLK_PER_MS - 1);

   logic [31:0]       pcount;
   logic              tick_s;
   logic              tick_q;
   logic [NUM_CH-1:0] ack_q;
   logic [NUM_CH-1:0] busy_q;
   logic [NUM_CH-1:0] done_q;
   logic [NUM_CH-1:0] elig;
   logic [DW-1:0]     rem [NUM_CH];
   logic [CW-1:0]     rr;
   logic [CW-1:0]     win;
   logic              gnt;

   assign tick_s = (pcount == PMAX);

   // A channel still showing ack this cycle was just served; skip it.
   assign elig = bus.req & ~busy_q & ~ack_q & ~bus.cancel;

   always_comb begin
      int idx;
      gnt = 1'b0;
      win = '0;
      idx = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (int'(rr) + k) % NUM_CH;
         if (!gnt && elig[idx]) begin
            gnt = 1'b1;
            win = CW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcount <= '0;
         tick_q <= 1'b0;
         rr     <= '0;
         ack_q  <= '0;
         busy_q <= '0;
         done_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            rem[i] <= '0;
         end
      end else begin
         pcount <= tick_s ? '0 : pcount + 32'd1;
         tick_q <= tick_s;
         ack_q  <= '0;
         done_q <= '0;
         if (gnt) begin
            rr <= (win == CW'(NUM_CH - 1)) ? '0 : win + 1'b1;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (gnt && win == CW'(i)) begin
               // Grant edge never counts a tick; zero delay completes at once.
               ack_q[i] <= 1'b1;
               if (bus.delay_ms[i*DW +: DW] == '0) begin
                  done_q[i] <= 1'b1;
               end else begin
                  busy_q[i] <= 1'b1;
                  rem[i]    <= bus.delay_ms[i*DW +: DW];
               end
            end else if (busy_q[i]) begin
               if (bus.cancel[i]) begin
                  busy_q[i] <= 1'b0;
               end else if (tick_s) begin
                  if (rem[i] == DW'(1)) begin
                     busy_q[i] <= 1'b0;
                     done_q[i] <= 1'b1;
                  end else begin
                     rem[i] <= rem[i] - 1'b1;
                  end
               end
            end
         end
      end
   end

   assign bus.ack  = ack_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.tick = tick_q;
endmodule
